// File: rtl/decade_chain_ctrl.sv
// Sequencer for a two-stage 74160-style decade cascade: programmable divide-by-(100-preset) timer.
// Optional snapshot of the cascade count on stop is built when DECADE_CHAIN_SNAPSHOT_EN is defined.
module decade_chain_ctrl (
    input  logic       cp,
    input  logic       mr_n,
    input  logic       start,
    input  logic [7:0] period,
    input  logic       reload,
    input  logic       stop,
    input  logic       tc_in,
    input  logic [3:0] q_lo,
    input  logic [3:0] q_hi,
    output logic       pe_n,
    output logic [3:0] p_lo,
    output logic [3:0] p_hi,
    output logic       cep,
    output logic       cet,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] snap
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t     state;
    logic [7:0] preset;
    logic       mode;
    logic       done_fr;
    logic       err_q;
    logic       period_bcd;
    logic       run_go;

    assign period_bcd = (period[7:4] <= 4'd9) && (period[3:0] <= 4'd9);

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            state   <= IDLE;
            preset  <= 8'h00;
            mode    <= 1'b0;
            done_fr <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_fr <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (period_bcd) begin
                            preset <= period;
                            mode   <= reload;
                            state  <= LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                // The cascade still takes the preset on an aborted LOAD edge.
                LOAD: state <= stop ? IDLE : RUN;
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (tc_in) begin
                        if (mode) done_fr <= 1'b1;
                        else      state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stop gates the count enables in the same cycle so the abort edge never counts.
    assign run_go = (state == RUN) && !stop;
    assign cep    = run_go;
    assign cet    = run_go;
    assign pe_n   = !((state == LOAD) || (run_go && tc_in && mode));
    assign p_lo   = preset[3:0];
    assign p_hi   = preset[7:4];
    assign busy   = (state != IDLE);
    assign done   = (state == DONE) || done_fr;
    assign err    = err_q;

`ifdef DECADE_CHAIN_SNAPSHOT_EN
    logic [7:0] snap_q;

    always_ff @(posedge cp or negedge mr_n) begin
        if (!mr_n) begin
            snap_q <= 8'h00;
        end else if ((state == RUN) && stop) begin
            snap_q <= {q_hi, q_lo};
        end
    end

    assign snap = snap_q;
`else
    logic unused_q;
    assign unused_q = ^{q_hi, q_lo};
    assign snap     = 8'h00;
`endif

endmodule

// File: doc/decade_chain_ctrl.md
# decade_chain_ctrl

Sequencer for a two-stage cascade of 74160-style synchronous decade counters. It forms a programmable divide-by-N timer for the video terminal's timing chain. The block drives the parallel-enable, preset and count-enable pins of the cascade, watches the cascade terminal count, and reports one-shot or periodic completion to the requester. The counters remain separate instances: this block owns only sequencing.

## Interface
Parameters: none.

Ports:
- cp  in  1  clock; all state changes on rising edge
- mr_n  in  1  master reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- period  in  8  BCD preset {hi,lo}; each digit must be 0..9
- reload  in  1  1 = free-running, 0 = one-shot; latched with start
- stop  in  1  abort; honoured in LOAD and RUN
- tc_in  in  1  terminal count of high stage (cascade tc: asserted at 99 with enables high)
- q_lo  in  4  low-stage count
- q_hi  in  4  high-stage count
- pe_n  out  1  parallel enable to both stages, active-low
- p_lo  out  4  preset to low stage
- p_hi  out  4  preset to high stage
- cep  out  1  count enable (parallel) to both stages
- cet  out  1  count enable (trickle) to low stage; high-stage cet is low-stage tc
- busy  out  1  high in LOAD, RUN, DONE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: start rejected, non-BCD period
- snap  out  8  {q_hi,q_lo} captured on stop

## Operation
- States: IDLE, LOAD, RUN, DONE. Encoded state is registered; outputs decode from state except where noted.
- Event priority: mr_n > stop > tc_in > start.
- IDLE:
  - pe_n=1, cep=cet=0.
  - If start=1 and both digits are ≤9: latch period into preset register and reload into mode register, then go to LOAD.
  - If start=1 and either digit is >9: err=1 for the following cycle, stay IDLE, preset unchanged.
- LOAD:
  - pe_n=0, {p_hi,p_lo}=preset, cep=cet=0.
  - Next edge loads the cascade and goes to RUN.
  - stop=1: go to IDLE; cascade still loads.
- RUN:
  - pe_n=1, cep=cet=~stop (combinational gate).
  - tc_in=1 and mode=free-running: pe_n=0 combinationally. Load overrides count at that edge, so the cascade reloads the preset. done=1 next cycle; stay in RUN.
  - tc_in=1 and mode=one-shot: cascade wraps to 00 at that edge; go to DONE.
  - stop=1: cep=cet=0 during that cycle. Capture {q_hi,q_lo} into snap; go to IDLE; no done.
- DONE: done=1, cep=cet=0, pe_n=1; next edge goes to IDLE.
- Free-running done: registered one cycle after each tc_in edge.
- start while busy: ignored, no err.
- Period (cycles from first RUN edge to tc edge inclusive) = 100 − preset. Preset 00 → 100; preset 99 → 1, with tc_in already high in the first RUN cycle.
- Reset values:
  - state=IDLE, pe_n=1, p_lo=p_hi=0, cep=cet=0
  - busy=0, done=0, err=0, snap=00, preset=00, mode=0
- Reset mid-operation: outputs return to reset values immediately (asynchronous). Counter contents are the counters' own reset responsibility.

## Timing
- start sampled at edge E0 → LOAD during [E0,E1]. Preset enters counters at E1. First count at E2.
- One-shot, preset P:
  - tc_in high during cycle ending at edge E1+(100−P); DONE in the following cycle.
  - done high exactly one cycle; busy falls at the next edge.
  - start→done latency: 101−P+1 edges.
- Free-running:
  - done pulses every 100−P cycles, first pulse one cycle after first tc edge.
  - No dead cycle between periods.
- stop asserted in cycle ending at edge S: no count at S; IDLE from S. snap valid from S, holds until next stop capture.
- err is registered: high in the cycle after the rejected start.

## Configuration
- DECADE_CHAIN_SNAPSHOT_EN defined: snap register built and captured on stop in RUN as above.
- Not defined: snap tied to 8'h00, q_lo/q_hi unused, no capture logic.
- All other behaviour is identical in both configurations.

## Test plan
- Bench instantiates two decade counters in cascade driven by this block.
- One-shot, period=8'h95, reload=0, start pulse → tc_in after 5 RUN cycles. Then done=1 for 1 cycle, busy=0 the cycle after, counters read 00.
- Free-running, period=8'h90, reload=1 → done pulses every 10 cycles, at least 4 periods. Counters cycle 90..99 with no gap; pe_n low only in LOAD and on each tc cycle.
- period=8'h00 one-shot → done exactly 100 cycles after first count. period=8'h99 → tc_in in first RUN cycle, done 1 cycle later.
- period=8'h3A with start → err=1 one cycle, busy stays 0, pe_n never low. Then period=8'h42 with start → normal run of 58 cycles.
- Free-running period=8'h50, stop asserted when counters read 8'h63 → no further count, snap=8'h63 (macro on) or 8'h00 (macro off), state IDLE, no done.
- mr_n pulled low mid-RUN → pe_n=1, cep=cet=0, busy=0 asynchronously. After release, a start with period=8'h97 completes in 3 cycles.
